reg_bank: RTL and testbench
===========================

# reg_bank

32 × 32-bit MIPS general-purpose register bank. It consumes the 5-bit destination-register address produced by the datapath's write-register select stage and decodes it into one-hot write enables. It serves two combinational read ports (rs/rt) to the datapath. It also provides a handshaked dump sequencer that streams all 32 registers to the testbench or debug monitor.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register address width; NREGS = 2**ADDR_W.
- `SP_RESET`, default 227: reset value of register 29 ($sp).
- `clk`  in  1  clock; every state element updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  destination register.
- `wr_data`  in  DATA_W  write data.
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  read addresses (rs, rt).
- `rd_data_a`, `rd_data_b`  out  DATA_W  read data.
- `dump_req`  in  1  starts a full-bank dump.
- `dump_busy`  out  1  high from the cycle after acceptance through DUMP_DONE.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_idx`  out  ADDR_W  register index of the current beat.
- `dump_data`  out  DATA_W  contents of register `dump_idx`.
- `dump_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Write decode: one-hot(wr_addr) AND wr_en gives a 32-bit enable vector. Bit 0 is always forced to 0, so register 0 is hardwired to zero and writes to it are silently dropped.
- Reads are combinational from the stored array. There is no write-through bypass: a read of the register being written returns the old value in the write cycle and the new value from the next cycle.
- Reset state:
  - All registers are 0, except reg 29, which is SP_RESET.
  - The FSM is in DUMP_IDLE.
  - dump_valid, dump_busy and dump_done are 0; dump_idx is 0.
- Dump FSM states:
  - DUMP_IDLE: when dump_req is 1, set idx to 0 and go to DUMP_SEND.
  - DUMP_SEND: dump_valid is 1. On dump_valid && dump_ready: if idx == NREGS-1, go to DUMP_DONE; otherwise increment idx.
  - DUMP_DONE: dump_done is 1 for exactly this cycle, then go to DUMP_IDLE.
- dump_valid never drops while in DUMP_SEND until the beat is accepted. dump_idx is stable while dump_valid && !dump_ready.
- dump_data = reg[dump_idx], read combinationally, so a write to that register while the beat is stalled is reflected immediately. Writes are never blocked by a dump.
- dump_req is ignored outside DUMP_IDLE. It is level-sampled, so if it is still high in the cycle after DUMP_DONE a new dump starts.
- idx is ADDR_W bits and never wraps inside a dump; the terminal check is idx == NREGS-1.
- Reset asserted mid-dump aborts the dump in the same edge: return to DUMP_IDLE with no dump_done pulse, and re-initialise the register contents.

## Timing
- Write: wr_en sampled at edge n; the value is readable from cycle n+1.
- Dump start: dump_req high in cycle n (in IDLE) gives dump_valid = 1 and dump_idx = 0 in cycle n+1.
- With dump_ready held high, the 32 beats occupy cycles n+1 to n+32 and dump_done is high in cycle n+33. dump_busy is high for cycles n+1 to n+33.
- Each cycle with dump_ready low adds one cycle.
- Read paths and the write decode are purely combinational. The register array and FSM are the only sequential elements.

## Structure
- Package `reg_bank_pkg`:
  - `NREGS`, `REG_ZERO` = 0, `REG_SP` = 29.
  - Enum `dump_state_t` {DUMP_IDLE, DUMP_SEND, DUMP_DONE}.
- Sub-module `decoder5to32`: parameterised ADDR_W to one-hot decoder with an enable input. It is the write-side counterpart of the datapath's 5-bit register select and is instantiated once for the write enables.

## Test plan
- Reset, then read all 32 addresses on both ports: every register reads 0 except reg 29, which reads 227.
- Write 0xDEADBEEF to reg 8; in the same cycle rd_addr_a = 8 reads the old value 0, and in the next cycle it reads 0xDEADBEEF. Write 0x12345678 to reg 0; reg 0 still reads 0.
- Write reg k = k*3 for k = 1..31, then pulse dump_req with dump_ready held high:
  - 32 consecutive beats with idx 0..31 and data 0, 3, …, 93.
  - dump_done pulses once, in the cycle after the beat with idx 31.
  - dump_busy is high for 33 cycles.
- During a dump, drop dump_ready for 3 cycles at idx 5 and write reg 5 = 0xA5A5A5A5 during the stall: idx holds at 5, dump_data changes to 0xA5A5A5A5, and no beat is skipped or repeated.
- Assert reset at beat idx 17: no dump_done pulse; in the next cycle dump_valid = 0, dump_busy = 0 and all registers are back at reset values. A new dump_req afterwards restarts at idx 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and types for the MIPS register bank.
//   NREGS    - register count for the default 5-bit address
//   REG_ZERO - hardwired-zero register index
//   REG_SP   - stack pointer register index (non-zero reset value)
//   dump_state_t - states of the register dump sequencer
package reg_bank_pkg;

    localparam int NREGS    = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/decoder5to32.sv
// decoder5to32: address to one-hot decoder with enable.
//   en     - when low, the output is all zeros
//   addr   - ADDR_W-bit select
//   onehot - 2**ADDR_W-bit one-hot result
module decoder5to32 #(
    parameter int ADDR_W = 5
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit MIPS general-purpose register bank with a
// handshaked dump sequencer.
//   clk, reset             - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  - single write port (reg 0 writes are dropped)
//   rd_addr_a/b, rd_data_a/b - two combinational read ports (no bypass)
//   dump_req               - start a full-bank dump (level-sampled in idle)
//   dump_valid/ready       - beat handshake; dump_idx/dump_data describe the beat
//   dump_busy              - high from the cycle after acceptance through done
//   dump_done              - one-cycle pulse after the last beat is taken
//
// state     | meaning
// DUMP_IDLE | waiting for dump_req
// DUMP_SEND | presenting reg[idx], advancing on each accepted beat
// DUMP_DONE | single-cycle completion pulse, then back to idle
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int NR = 2**ADDR_W;

    logic [NR-1:0]     wr_onehot;
    logic [NR-1:0]     wr_we;
    logic [DATA_W-1:0] regs_q [NR];
    logic [DATA_W-1:0] regs_d [NR];

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    decoder5to32 #(.ADDR_W(ADDR_W)) u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    // Register 0 is hardwired to zero: its enable is masked off.
    always_comb begin
        wr_we           = wr_onehot;
        wr_we[REG_ZERO] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            regs_d[i] = wr_we[i] ? wr_data : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];

    // Next-state also produces next-cycle output values so outputs are flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_req) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DUMP_SEND: begin
                if (dump_ready) begin
                    if (idx_q == ADDR_W'(NR - 1)) begin
                        state_d = DUMP_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = DUMP_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;
    assign dump_idx   = idx_q;
    // Combinational read so a write during a stalled beat shows up at once.
    assign dump_data  = regs_q[idx_q];

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        dump_req, dump_busy, dump_valid, dump_ready, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    reg_bank dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] data);
        chk({tag, "_valid"}, {31'd0, dump_valid}, 32'd1);
        chk($sformatf("%s_idx%0d", tag, idx), {27'd0, dump_idx}, idx);
        chk($sformatf("%s_data%0d", tag, idx), dump_data, data);
        chk($sformatf("%s_done%0d", tag, idx), {31'd0, dump_done}, 32'd0);
    endtask

    task automatic chk_reset_regs(input string tag);
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            rd_addr_b = 5'(31 - k);
            #1;
            chk($sformatf("%s_a%0d", tag, k), rd_data_a, (k == 29) ? 32'd227 : 32'd0);
            chk($sformatf("%s_b%0d", tag, 31 - k), rd_data_b, ((31 - k) == 29) ? 32'd227 : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; dump_req = 1'b0; dump_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, dump_valid}, 32'd0);
        chk("rst_busy",  {31'd0, dump_busy},  32'd0);
        chk("rst_done",  {31'd0, dump_done},  32'd0);
        chk("rst_idx",   {27'd0, dump_idx},   32'd0);
        chk_reset_regs("rst");

        // write reg 8: old value during the write cycle, new value after
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd8;
        #1;
        chk("wr8_same_cycle", rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr8_next_cycle", rd_data_a, 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr_b = 5'd0;
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr0_dropped", rd_data_b, 32'd0);

        // reg k = 3k, then a full dump with ready held high
        for (int k = 1; k < 32; k++) begin
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'(3 * k);
            tick();
        end
        wr_en = 1'b0;
        dump_ready = 1'b1; dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        busy_cnt = 0;
        for (int b = 0; b < 32; b++) begin
            chk_beat("d1", b, 32'(3 * b));
            if (dump_busy) busy_cnt++;
            tick();
        end
        chk("d1_done_pulse", {31'd0, dump_done}, 32'd1);
        chk("d1_valid_off",  {31'd0, dump_valid}, 32'd0);
        if (dump_busy) busy_cnt++;
        tick();
        chk("d1_done_once", {31'd0, dump_done}, 32'd0);
        chk("d1_busy_off",  {31'd0, dump_busy}, 32'd0);
        chk("d1_busy_cycles", busy_cnt, 32'd33);

        // dump with a 3-cycle stall at idx 5 and a write to reg 5 mid-stall
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_beat("d2", b, 32'(3 * b));
            tick();
        end
        dump_ready = 1'b0;
        #1;
        chk_beat("d2_stall1", 5, 32'd15);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1'b0;
        chk_beat("d2_stall2", 5, 32'hA5A5A5A5);
        tick();
        chk_beat("d2_stall3", 5, 32'hA5A5A5A5);
        tick();
        dump_ready = 1'b1;
        #1;
        chk_beat("d2_accept", 5, 32'hA5A5A5A5);
        tick();
        for (int b = 6; b < 32; b++) begin
            chk_beat("d2", b, 32'(3 * b));
            tick();
        end
        chk("d2_done_pulse", {31'd0, dump_done}, 32'd1);
        tick();

        // reset asserted at beat 17 aborts the dump
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int b = 0; b < 17; b++) begin
            chk_beat("d3", b, (b == 5) ? 32'hA5A5A5A5 : 32'(3 * b));
            tick();
        end
        chk_beat("d3_at_abort", 17, 32'd51);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", {31'd0, dump_valid}, 32'd0);
        chk("abort_busy",  {31'd0, dump_busy},  32'd0);
        chk("abort_done",  {31'd0, dump_done},  32'd0);
        chk_reset_regs("abort");
        tick();
        chk("abort_no_done", {31'd0, dump_done}, 32'd0);

        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        chk_beat("d4", 0, 32'd0);
        chk("d4_busy", {31'd0, dump_busy}, 32'd1);
        tick();
        chk_beat("d4", 1, 32'd0);
        tick();
        chk_beat("d4", 2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
